// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states, default width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mduOpT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mduStateT;

endpackage

// File: rtl/mult_div_unit_step.sv
// mdu_step: one combinational iteration, either shift-add multiply or restoring shift-subtract divide.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] addend,
  input  logic             divMode,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] operandNext
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             geq;

  always_comb begin
    sum     = {1'b0, acc} + (operand[0] ? {1'b0, addend} : '0);
    shifted = {acc, operand[WIDTH-1]};
    // remainder stays below the divisor, so the subtraction result always fits WIDTH bits
    diff    = shifted[WIDTH-1:0] - addend;
    geq     = shifted >= {1'b0, addend};
    if (divMode) begin
      accNext     = geq ? diff : shifted[WIDTH-1:0];
      operandNext = {operand[WIDTH-2:0], geq};
    end else begin
      accNext     = sum[WIDTH:1];
      operandNext = {sum[0], operand[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and start/busy/done handshake.
// Build option MDU_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; latches op, operand magnitudes and result signs
// RUN   | one step per cycle; the last step writes HI/LO and raises done
// FIN   | done cycle; on divide-by-zero it is entered from IDLE and first writes HI/LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outHi,
  output logic [WIDTH-1:0] outLo,
  output logic             divByZero
);

  mduStateT           state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc, opnd, addend, accNext, opNext;
  logic [WIDTH-1:0]   magA, magB, resHi, resLo;
  logic               isDiv, negRes, negRem;
  logic               divReq, signedOp, signA, signB, lastStep;
  logic [2*WIDTH-1:0] prodMag, prodFix;
`ifdef MDU_EARLY_TERM_EN
  logic [WIDTH-1:0]   mRem;
  logic [CNT_W-1:0]   shiftAmt;
`endif

  mdu_step #(.WIDTH(WIDTH)) uStep (
    .acc        (acc),
    .operand    (opnd),
    .addend     (addend),
    .divMode    (isDiv),
    .accNext    (accNext),
    .operandNext(opNext)
  );

  always_comb begin
    divReq   = (op == MDU_DIVU) || (op == MDU_DIV);
    signedOp = (op == MDU_MULT) || (op == MDU_DIV);
    signA    = signedOp & inA[WIDTH-1];
    signB    = signedOp & inB[WIDTH-1];
    magA     = signA ? -inA : inA;
    magB     = signB ? -inB : inB;
  end

  always_comb begin
    prodMag = {accNext, opNext};
`ifdef MDU_EARLY_TERM_EN
    // skipped steps would only have shifted the product right
    shiftAmt = CNT_W'(WIDTH - 1) - cnt;
    prodMag  = prodMag >> shiftAmt;
    lastStep = (cnt == CNT_W'(WIDTH - 1)) || (!isDiv && ((mRem >> 1) == '0));
`else
    lastStep = (cnt == CNT_W'(WIDTH - 1));
`endif
    prodFix = negRes ? -prodMag : prodMag;
    if (isDiv) begin
      resHi = negRem ? -accNext : accNext;
      resLo = negRes ? -opNext : opNext;
    end else begin
      resHi = prodFix[2*WIDTH-1:WIDTH];
      resLo = prodFix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      outHi     <= '0;
      outLo     <= '0;
      divByZero <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      addend    <= '0;
      isDiv     <= 1'b0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
`ifdef MDU_EARLY_TERM_EN
      mRem      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            divByZero <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            isDiv     <= divReq;
            negRes    <= signA ^ signB;
            negRem    <= signA;
            addend    <= divReq ? magB : magA;
`ifdef MDU_EARLY_TERM_EN
            mRem      <= magB;
`endif
            if (divReq && (inB == '0)) begin
              opnd  <= inA;
              state <= FIN;
            end else begin
              opnd  <= divReq ? magA : magB;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc  <= accNext;
          opnd <= opNext;
          cnt  <= cnt + 1'b1;
`ifdef MDU_EARLY_TERM_EN
          mRem <= mRem >> 1;
`endif
          if (lastStep) begin
            outHi <= resHi;
            outLo <= resLo;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            outHi     <= opnd;
            outLo     <= '1;
            divByZero <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
